branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
EX-stage resolution unit and the feedback end of the branch predictor interface. It evaluates each conditional branch and jalr in EX and compares the result against the prediction carried down the pipeline. It supplies `corrected_result` for the predictor's training path. On a mispredict it raises a registered `PL_flush` with the redirect PC, and presents the failed branch's type, PC and outcome in the `*_branch_failed` form that drives predictor and RAS rollback.

Parameters:
- FLUSH_CYCLES, 1: cycles `PL_flush` stays high per mispredict (1..3).
- RECOVER_CYCLES, 1: cycles after the flush window during which EX contents are treated as wrong-path and ignored (0..3).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PL_stall  in  1  pipeline stall; freezes evaluation and FSM.
- B_type_ex  in  1  EX holds a conditional branch.
- beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex  in  1 each  one-hot branch kind.
- jalr_ex  in  1  EX holds a jalr that used a RAS prediction.
- rs1_ex, rs2_ex  in  32  operands.
- pc_ex, imme_ex  in  32  branch PC and sign-extended offset.
- prediction_ex  in  1  taken prediction made at fetch.
- jalr_pc_prediction_ex  in  32  RAS-predicted target.
- corrected_result  out  1  actual taken outcome of the EX branch (combinational).
- PL_flush  out  1  registered flush request.
- redirect_pc  out  32  fetch target, valid while PL_flush=1.
- B_type_branch_failed, beq_branch_failed … bgeu_branch_failed  out  1 each  registered kind of the failed branch.
- pc_branch_filled  out  32  PC of the failed branch.
- B_type_result_branch_failed  out  1  actual outcome of the failed branch.
- ras_rollback_push_ex  out  1  registered: jalr target mispredicted.
- perf_branch_total, perf_branch_miss  out  32 each  performance counters.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- Compare rules:
  - eq: rs1==rs2.
  - lt: signed compare.
  - ltu: unsigned compare.
  - bne, bge, bgeu are the inverses of eq, lt, ltu.
- corrected_result = the selected compare when B_type_ex=1, else 0. Pure combinational, zero latency.
- Target arithmetic: pc_ex+imme_ex and pc_ex+4 are both mod 2^32; wrap-around is not flagged.
- Evaluation is enabled only when state==IDLE and PL_stall=0.
- Conditional mispredict: enabled, B_type_ex=1 and corrected_result!=prediction_ex.
  - redirect_pc = corrected_result ? pc_ex+imme_ex : pc_ex+4.
- jalr mispredict: enabled, jalr_ex=1 and ({rs1_ex+imme_ex}&~1)!=jalr_pc_prediction_ex.
  - redirect_pc = that computed target.
  - ras_rollback_push_ex=1.
- B_type_ex and jalr_ex are mutually exclusive. If both are seen, B_type takes priority and the jalr check is skipped.
- On mispredict at edge N: the failed-branch registers, redirect_pc and PL_flush=1 load at edge N. They are visible in cycle N+1; latency is 1 cycle from EX evaluation.
- FSM states:
  - IDLE, on mispredict → FLUSH (count=FLUSH_CYCLES).
  - FLUSH: PL_flush=1. Decrement each cycle regardless of PL_stall, since flush overrides stall. At 0 → RECOVER (count=RECOVER_CYCLES), or → IDLE if RECOVER_CYCLES=0.
  - RECOVER: PL_flush=0; EX ignored. Decrement only when PL_stall=0; at 0 → IDLE.
- Failed-branch registers hold their value through FLUSH/RECOVER and clear to 0 on return to IDLE. Consumers gate them with PL_flush.
- A second mispredict during FLUSH/RECOVER is impossible by construction: those cycles are ignored.
- PL_stall=1 in IDLE: no evaluation, no counter update, outputs hold.
- rst_n low mid-flush: immediate return to IDLE with all outputs 0. No flush resumes after release.

Optional Feature:
- BRANCH_RESOLVER_PERF_CNT_EN defined:
  - perf_branch_total increments on every enabled evaluation with B_type_ex or jalr_ex.
  - perf_branch_miss increments on every mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: both ports tied to 0 and no counter flops are synthesized.

Test Plan:
- Correct predict: beq, rs1=rs2=5, prediction=1 → corrected_result=1, PL_flush stays 0 for 4 cycles.
- Taken mispredict: blt, rs1=-1, rs2=1, pc=0x100, imme=0x40, prediction=0 → next cycle:
  - PL_flush=1, redirect_pc=0x140, blt_branch_failed=1, pc_branch_filled=0x100, B_type_result_branch_failed=1;
  - then 1 RECOVER cycle, then IDLE.
- Not-taken mispredict, unsigned: bltu, rs1=0xFFFFFFFF, rs2=1, prediction=1, pc=0xFFFFFFFC → redirect_pc=0x00000000 (wrap), B_type_result_branch_failed=0.
- jalr: rs1=0x2000, imme=5, prediction 0x2004 → target 0x2004, no flush; prediction 0x3000 → PL_flush=1, redirect_pc=0x2004, ras_rollback_push_ex=1.
- Stall and reset:
  - Mispredict presented with PL_stall=1 → no flush until PL_stall drops.
  - Assert rst_n=0 during FLUSH → all outputs 0 in the same cycle, IDLE after release.
- With macro, 3 branches, 1 miss → perf_branch_total=3, perf_branch_miss=1. Without macro → both 0.

Source files
------------

// File: rtl/branch_resolver_if.sv
// EX-stage branch resolution bundle: operands/prediction in, flush request and
// failed-branch rollback information out.
interface branch_resolver_if;
    logic        PL_stall;
    logic        B_type_ex;
    logic        beq_ex;
    logic        bne_ex;
    logic        blt_ex;
    logic        bge_ex;
    logic        bltu_ex;
    logic        bgeu_ex;
    logic        jalr_ex;
    logic [31:0] rs1_ex;
    logic [31:0] rs2_ex;
    logic [31:0] pc_ex;
    logic [31:0] imme_ex;
    logic        prediction_ex;
    logic [31:0] jalr_pc_prediction_ex;

    logic        corrected_result;
    logic        PL_flush;
    logic [31:0] redirect_pc;
    logic        B_type_branch_failed;
    logic        beq_branch_failed;
    logic        bne_branch_failed;
    logic        blt_branch_failed;
    logic        bge_branch_failed;
    logic        bltu_branch_failed;
    logic        bgeu_branch_failed;
    logic [31:0] pc_branch_filled;
    logic        B_type_result_branch_failed;
    logic        ras_rollback_push_ex;
    logic [31:0] perf_branch_total;
    logic [31:0] perf_branch_miss;

    modport master (
        output PL_stall, B_type_ex, beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex,
               jalr_ex, rs1_ex, rs2_ex, pc_ex, imme_ex, prediction_ex, jalr_pc_prediction_ex,
        input  corrected_result, PL_flush, redirect_pc, B_type_branch_failed,
               beq_branch_failed, bne_branch_failed, blt_branch_failed, bge_branch_failed,
               bltu_branch_failed, bgeu_branch_failed, pc_branch_filled,
               B_type_result_branch_failed, ras_rollback_push_ex,
               perf_branch_total, perf_branch_miss
    );

    modport slave (
        input  PL_stall, B_type_ex, beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex,
               jalr_ex, rs1_ex, rs2_ex, pc_ex, imme_ex, prediction_ex, jalr_pc_prediction_ex,
        output corrected_result, PL_flush, redirect_pc, B_type_branch_failed,
               beq_branch_failed, bne_branch_failed, blt_branch_failed, bge_branch_failed,
               bltu_branch_failed, bgeu_branch_failed, pc_branch_filled,
               B_type_result_branch_failed, ras_rollback_push_ex,
               perf_branch_total, perf_branch_miss
    );
endinterface

// File: rtl/branch_resolver.sv
// EX-stage branch/jalr resolver with registered flush and predictor rollback info.
// Optional saturating performance counters: define BRANCH_RESOLVER_PERF_CNT_EN.
module branch_resolver #(
    parameter int FLUSH_CYCLES   = 1,
    parameter int RECOVER_CYCLES = 1
) (
    input logic              clk,
    input logic              rst_n,
    branch_resolver_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FLUSH   = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    localparam logic [1:0] FLUSH_CNT   = 2'(FLUSH_CYCLES);
    localparam logic [1:0] RECOVER_CNT = 2'(RECOVER_CYCLES);

    logic        eq, lt, ltu, cmp_sel;
    logic        enabled, b_miss, j_miss, miss, go_idle;
    logic [31:0] jalr_target, miss_target;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;
    logic        btype_q, btype_d;
    logic [5:0]  kind_q, kind_d;
    logic [31:0] pc_fail_q, pc_fail_d;
    logic        result_fail_q, result_fail_d;
    logic        ras_push_q, ras_push_d;

    always_comb begin
        eq      = (bus.rs1_ex == bus.rs2_ex);
        lt      = ($signed(bus.rs1_ex) < $signed(bus.rs2_ex));
        ltu     = (bus.rs1_ex < bus.rs2_ex);
        cmp_sel = 1'b0;
        if (bus.beq_ex)       cmp_sel = eq;
        else if (bus.bne_ex)  cmp_sel = !eq;
        else if (bus.blt_ex)  cmp_sel = lt;
        else if (bus.bge_ex)  cmp_sel = !lt;
        else if (bus.bltu_ex) cmp_sel = ltu;
        else if (bus.bgeu_ex) cmp_sel = !ltu;
    end

    assign bus.corrected_result = bus.B_type_ex & cmp_sel;

    // A conditional branch in EX shadows any jalr flag seen in the same cycle.
    always_comb begin
        enabled     = (state_q == IDLE) && !bus.PL_stall;
        jalr_target = (bus.rs1_ex + bus.imme_ex) & ~32'd1;
        b_miss      = enabled && bus.B_type_ex && (bus.corrected_result != bus.prediction_ex);
        j_miss      = enabled && !bus.B_type_ex && bus.jalr_ex &&
                      (jalr_target != bus.jalr_pc_prediction_ex);
        miss        = b_miss || j_miss;
        if (b_miss)
            miss_target = bus.corrected_result ? (bus.pc_ex + bus.imme_ex) : (bus.pc_ex + 32'd4);
        else
            miss_target = jalr_target;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_d       = flush_q;
        redirect_d    = redirect_q;
        btype_d       = btype_q;
        kind_d        = kind_q;
        pc_fail_d     = pc_fail_q;
        result_fail_d = result_fail_q;
        ras_push_d    = ras_push_q;
        go_idle       = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d       = FLUSH;
                    cnt_d         = FLUSH_CNT;
                    flush_d       = 1'b1;
                    redirect_d    = miss_target;
                    btype_d       = b_miss;
                    kind_d        = b_miss ? {bus.bgeu_ex, bus.bltu_ex, bus.bge_ex,
                                              bus.blt_ex, bus.bne_ex, bus.beq_ex} : 6'd0;
                    pc_fail_d     = bus.pc_ex;
                    result_fail_d = b_miss && bus.corrected_result;
                    ras_push_d    = j_miss;
                end
            end
            // Flush outranks stall, so this window always drains on schedule.
            FLUSH: begin
                if (cnt_q <= 2'd1) begin
                    flush_d = 1'b0;
                    if (RECOVER_CNT == 2'd0) begin
                        go_idle = 1'b1;
                    end else begin
                        state_d = RECOVER;
                        cnt_d   = RECOVER_CNT;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RECOVER: begin
                if (!bus.PL_stall) begin
                    if (cnt_q <= 2'd1) go_idle = 1'b1;
                    else               cnt_d   = cnt_q - 2'd1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d       = IDLE;
            cnt_d         = 2'd0;
            flush_d       = 1'b0;
            redirect_d    = 32'd0;
            btype_d       = 1'b0;
            kind_d        = 6'd0;
            pc_fail_d     = 32'd0;
            result_fail_d = 1'b0;
            ras_push_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            flush_q       <= 1'b0;
            redirect_q    <= 32'd0;
            btype_q       <= 1'b0;
            kind_q        <= 6'd0;
            pc_fail_q     <= 32'd0;
            result_fail_q <= 1'b0;
            ras_push_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            btype_q       <= btype_d;
            kind_q        <= kind_d;
            pc_fail_q     <= pc_fail_d;
            result_fail_q <= result_fail_d;
            ras_push_q    <= ras_push_d;
        end
    end

    assign bus.PL_flush                    = flush_q;
    assign bus.redirect_pc                 = redirect_q;
    assign bus.B_type_branch_failed        = btype_q;
    assign bus.beq_branch_failed           = kind_q[0];
    assign bus.bne_branch_failed           = kind_q[1];
    assign bus.blt_branch_failed           = kind_q[2];
    assign bus.bge_branch_failed           = kind_q[3];
    assign bus.bltu_branch_failed          = kind_q[4];
    assign bus.bgeu_branch_failed          = kind_q[5];
    assign bus.pc_branch_filled            = pc_fail_q;
    assign bus.B_type_result_branch_failed = result_fail_q;
    assign bus.ras_rollback_push_ex        = ras_push_q;

`ifdef BRANCH_RESOLVER_PERF_CNT_EN
    logic        branch_seen;
    logic [31:0] total_q, total_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        branch_seen = enabled && (bus.B_type_ex || bus.jalr_ex);
        total_d     = total_q;
        miss_cnt_d  = miss_cnt_q;
        if (branch_seen && (total_q != 32'hFFFF_FFFF)) total_d    = total_q + 32'd1;
        if (miss && (miss_cnt_q != 32'hFFFF_FFFF))     miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q    <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            total_q    <= total_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.perf_branch_total = total_q;
    assign bus.perf_branch_miss  = miss_cnt_q;
`else
    assign bus.perf_branch_total = 32'd0;
    assign bus.perf_branch_miss  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed-vector bench for branch_resolver; inputs change and outputs are sampled
// on the falling edge, away from the rising edge the DUT acts on.
module tb_branch_resolver;

    localparam logic [6:0] K_NONE = 7'h00;
    localparam logic [6:0] K_BEQ  = 7'h01;
    localparam logic [6:0] K_BNE  = 7'h02;
    localparam logic [6:0] K_BLT  = 7'h04;
    localparam logic [6:0] K_BGE  = 7'h08;
    localparam logic [6:0] K_BLTU = 7'h10;
    localparam logic [6:0] K_JALR = 7'h40;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;
    logic [31:0] expTotal;
    logic [31:0] expMiss;

    branch_resolver_if bus ();

    branch_resolver #(
        .FLUSH_CYCLES  (1),
        .RECOVER_CYCLES(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] kind, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] pc, input logic [31:0] imme, input logic pred,
                                 input logic [31:0] jpred);
        bus.B_type_ex             = |kind[5:0];
        bus.beq_ex                = kind[0];
        bus.bne_ex                = kind[1];
        bus.blt_ex                = kind[2];
        bus.bge_ex                = kind[3];
        bus.bltu_ex               = kind[4];
        bus.bgeu_ex               = kind[5];
        bus.jalr_ex               = kind[6];
        bus.rs1_ex                = rs1;
        bus.rs2_ex                = rs2;
        bus.pc_ex                 = pc;
        bus.imme_ex               = imme;
        bus.prediction_ex         = pred;
        bus.jalr_pc_prediction_ex = jpred;
    endtask

    task automatic clearEx();
        applyStimulus(K_NONE, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    function automatic logic [31:0] kindsObs();
        return {25'd0, bus.B_type_branch_failed, bus.bgeu_branch_failed, bus.bltu_branch_failed,
                bus.bge_branch_failed, bus.blt_branch_failed, bus.bne_branch_failed,
                bus.beq_branch_failed};
    endfunction

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        bus.PL_stall = 1'b0;
        clearEx();

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_flush", {31'd0, bus.PL_flush}, 32'd0);
        checkOutput("reset_redirect", bus.redirect_pc, 32'd0);
        checkOutput("reset_kinds", kindsObs(), 32'd0);
        checkOutput("reset_pc_failed", bus.pc_branch_filled, 32'd0);
        checkOutput("reset_perf_total", bus.perf_branch_total, 32'd0);
        checkOutput("reset_perf_miss", bus.perf_branch_miss, 32'd0);
        rst_n = 1'b1;

        // Correctly predicted beq: no flush for four cycles.
        @(negedge clk);
        applyStimulus(K_BEQ, 32'd5, 32'd5, 32'h80, 32'h10, 1'b1, 32'd0);
        #1 checkOutput("beq_corrected", {31'd0, bus.corrected_result}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clearEx();
            checkOutput($sformatf("beq_noflush%0d", i), {31'd0, bus.PL_flush}, 32'd0);
        end

        // Taken mispredict on signed blt.
        applyStimulus(K_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 1'b0, 32'd0);
        #1 checkOutput("blt_corrected", {31'd0, bus.corrected_result}, 32'd1);
        @(negedge clk);
        checkOutput("blt_flush", {31'd0, bus.PL_flush}, 32'd1);
        checkOutput("blt_redirect", bus.redirect_pc, 32'h140);
        checkOutput("blt_kinds", kindsObs(), 32'h44);
        checkOutput("blt_pc_failed", bus.pc_branch_filled, 32'h100);
        checkOutput("blt_result", {31'd0, bus.B_type_result_branch_failed}, 32'd1);
        clearEx();
        @(negedge clk);
        checkOutput("blt_recover_flush", {31'd0, bus.PL_flush}, 32'd0);
        checkOutput("blt_recover_hold", kindsObs(), 32'h44);
        @(negedge clk);
        checkOutput("blt_idle_kinds", kindsObs(), 32'd0);
        checkOutput("blt_idle_pc", bus.pc_branch_filled, 32'd0);

        // Not-taken unsigned mispredict at the top of memory: fall-through wraps to 0.
        applyStimulus(K_BLTU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'h20, 1'b1, 32'd0);
        #1 checkOutput("bltu_corrected", {31'd0, bus.corrected_result}, 32'd0);
        @(negedge clk);
        checkOutput("bltu_flush", {31'd0, bus.PL_flush}, 32'd1);
        checkOutput("bltu_redirect", bus.redirect_pc, 32'h0);
        checkOutput("bltu_kinds", kindsObs(), 32'h50);
        checkOutput("bltu_result", {31'd0, bus.B_type_result_branch_failed}, 32'd0);
        clearEx();
        @(negedge clk);
        // A would-be mispredict sitting in EX during RECOVER is wrong-path and ignored.
        applyStimulus(K_BEQ, 32'd1, 32'd2, 32'h300, 32'h8, 1'b1, 32'd0);
        @(negedge clk);
        clearEx();
        checkOutput("recover_ignored", {31'd0, bus.PL_flush}, 32'd0);

        // jalr with correct RAS prediction.
        applyStimulus(K_JALR, 32'h2000, 32'd0, 32'h400, 32'd5, 1'b0, 32'h2004);
        #1 checkOutput("jalr_corrected", {31'd0, bus.corrected_result}, 32'd0);
        @(negedge clk);
        checkOutput("jalr_ok_flush", {31'd0, bus.PL_flush}, 32'd0);

        // jalr with wrong RAS prediction.
        applyStimulus(K_JALR, 32'h2000, 32'd0, 32'h404, 32'd5, 1'b0, 32'h3000);
        @(negedge clk);
        checkOutput("jalr_miss_flush", {31'd0, bus.PL_flush}, 32'd1);
        checkOutput("jalr_miss_redirect", bus.redirect_pc, 32'h2004);
        checkOutput("jalr_miss_ras", {31'd0, bus.ras_rollback_push_ex}, 32'd1);
        checkOutput("jalr_miss_kinds", kindsObs(), 32'd0);
        checkOutput("jalr_miss_pc", bus.pc_branch_filled, 32'h404);
        clearEx();
        @(negedge clk);
        @(negedge clk);
        checkOutput("jalr_idle_ras", {31'd0, bus.ras_rollback_push_ex}, 32'd0);

        // Mispredicting bge held behind a stall.
        bus.PL_stall = 1'b1;
        applyStimulus(K_BGE, 32'd3, 32'd5, 32'h200, 32'h10, 1'b1, 32'd0);
        @(negedge clk);
        checkOutput("stall_noflush0", {31'd0, bus.PL_flush}, 32'd0);
        @(negedge clk);
        checkOutput("stall_noflush1", {31'd0, bus.PL_flush}, 32'd0);
        bus.PL_stall = 1'b0;
        @(negedge clk);
        checkOutput("stall_release_flush", {31'd0, bus.PL_flush}, 32'd1);
        checkOutput("stall_release_redirect", bus.redirect_pc, 32'h204);
        checkOutput("stall_release_kinds", kindsObs(), 32'h48);
        clearEx();
        @(negedge clk);
        @(negedge clk);

`ifdef BRANCH_RESOLVER_PERF_CNT_EN
        expTotal = 32'd6;
        expMiss  = 32'd4;
`else
        expTotal = 32'd0;
        expMiss  = 32'd0;
`endif
        checkOutput("perf_total_mid", bus.perf_branch_total, expTotal);
        checkOutput("perf_miss_mid", bus.perf_branch_miss, expMiss);

        // Reset arriving mid-flush.
        applyStimulus(K_BEQ, 32'd1, 32'd2, 32'h500, 32'h10, 1'b1, 32'd0);
        @(negedge clk);
        clearEx();
        checkOutput("rst_pre_flush", {31'd0, bus.PL_flush}, 32'd1);
        checkOutput("rst_pre_redirect", bus.redirect_pc, 32'h504);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_flush", {31'd0, bus.PL_flush}, 32'd0);
        checkOutput("rst_mid_redirect", bus.redirect_pc, 32'd0);
        checkOutput("rst_mid_kinds", kindsObs(), 32'd0);
        checkOutput("rst_mid_pc", bus.pc_branch_filled, 32'd0);
        checkOutput("rst_mid_perf", bus.perf_branch_total, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_after_flush", {31'd0, bus.PL_flush}, 32'd0);
        @(negedge clk);
        checkOutput("rst_after_flush2", {31'd0, bus.PL_flush}, 32'd0);

        // Three branches, one miss, counted from a fresh reset.
        applyStimulus(K_BEQ, 32'd7, 32'd7, 32'h600, 32'h10, 1'b1, 32'd0);
        @(negedge clk);
        applyStimulus(K_BNE, 32'd1, 32'd2, 32'h604, 32'h10, 1'b1, 32'd0);
        @(negedge clk);
        checkOutput("bne_ok_flush", {31'd0, bus.PL_flush}, 32'd0);
        applyStimulus(K_BGE, 32'hFFFF_FFFB, 32'd2, 32'h608, 32'h10, 1'b1, 32'd0);
        #1 checkOutput("bge_neg_corrected", {31'd0, bus.corrected_result}, 32'd0);
        @(negedge clk);
        clearEx();
        checkOutput("bge_neg_redirect", bus.redirect_pc, 32'h60C);
        @(negedge clk);
        @(negedge clk);
`ifdef BRANCH_RESOLVER_PERF_CNT_EN
        expTotal = 32'd3;
        expMiss  = 32'd1;
`else
        expTotal = 32'd0;
        expMiss  = 32'd0;
`endif
        checkOutput("perf_total_final", bus.perf_branch_total, expTotal);
        checkOutput("perf_miss_final", bus.perf_branch_miss, expMiss);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
